grid_io_tile_param: RTL

//  Parametrised IO grid tile: NUM_SUBTILE embedded-IO subtiles, each with a CFG_BITS-bit config shift register.
//  All subtile registers are chained into one ccff scan path.

---
 rtl/grid_io_pkg.sv | 16 +
 rtl/grid_io_subtile.sv | 59 +++++
 rtl/grid_io_tile_param.sv | 83 ++++++++
 3 files changed

// File: rtl/grid_io_pkg.sv
// Shared definitions for the grid IO tile: config bit positions and config-load FSM encoding.
package grid_io_pkg;

  localparam int CFG_DIR     = 0;
  localparam int CFG_IN_REG  = 1;
  localparam int CFG_OUT_REG = 2;
  localparam int CFG_BITS_IO = 3;

  typedef enum logic [1:0] {
    IO_CFG_IDLE  = 2'd0,
    IO_CFG_SHIFT = 2'd1,
    IO_CFG_DONE  = 2'd2,
    IO_CFG_ERR   = 2'd3
  } io_cfg_state_t;

endpackage

// File: rtl/grid_io_subtile.sv
// One embedded-IO subtile: 3-bit ccff segment, IO data registers, gated pad muxes.
// Optional SOC_IN 2-flop synchroniser selected by macro IO_INPUT_SYNC_EN.
module grid_io_subtile
  import grid_io_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_shift_en,
  input  logic i_ccff_head,
  output logic o_ccff_tail,
  input  logic i_gate_n,
  input  logic i_soc_in,
  output logic o_soc_out,
  output logic o_soc_dir,
  input  logic i_outpad,
  output logic o_inpad
);

  logic [CFG_BITS_IO-1:0] r_cfg;
  logic                   r_out_q;
  logic                   r_in_q;
  logic                   w_in_src;
  logic                   w_dir;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cfg   <= '0;
      r_out_q <= 1'b0;
      r_in_q  <= 1'b0;
    end else begin
      if (i_shift_en) r_cfg <= {r_cfg[CFG_BITS_IO-2:0], i_ccff_head};
      // data registers sample continuously so they hold fresh values when gating lifts
      r_out_q <= i_outpad;
      r_in_q  <= w_in_src;
    end
  end

`ifdef IO_INPUT_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], i_soc_in};
  end

  assign w_in_src = r_sync[1];
`else
  assign w_in_src = i_soc_in;
`endif

  assign w_dir       = r_cfg[CFG_DIR];
  assign o_ccff_tail = r_cfg[CFG_BITS_IO-1];
  assign o_soc_dir   = i_gate_n & w_dir;
  assign o_soc_out   = (i_gate_n & w_dir)
                       ? (r_cfg[CFG_OUT_REG] ? r_out_q : i_outpad) : 1'b0;
  assign o_inpad     = (i_gate_n & ~w_dir)
                       ? (r_cfg[CFG_IN_REG] ? r_in_q : w_in_src) : 1'b0;

endmodule

// File: rtl/grid_io_tile_param.sv
// Parametrised IO grid tile: NUM_SUBTILE subtiles on one ccff chain plus a bit-count checker FSM.
// Build option: IO_INPUT_SYNC_EN adds a 2-flop synchroniser on every SOC_IN pad.
module grid_io_tile_param
  import grid_io_pkg::*;
#(
  parameter int NUM_SUBTILE = 6,
  parameter int CFG_BITS    = 3
) (
  input  logic                   prog_clk,
  input  logic                   prog_reset_n,
  input  logic                   config_enable,
  input  logic                   ccff_head,
  output logic                   ccff_tail,
  input  logic [NUM_SUBTILE-1:0] gfpga_pad_EMBEDDED_IO_SOC_IN,
  output logic [NUM_SUBTILE-1:0] gfpga_pad_EMBEDDED_IO_SOC_OUT,
  output logic [NUM_SUBTILE-1:0] gfpga_pad_EMBEDDED_IO_SOC_DIR,
  input  logic [NUM_SUBTILE-1:0] io_outpad,
  output logic [NUM_SUBTILE-1:0] io_inpad,
  output logic                   cfg_done,
  output logic                   cfg_err
);

  localparam int TOTAL = NUM_SUBTILE * CFG_BITS;
  localparam int CW    = $clog2(TOTAL + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(TOTAL);
  localparam logic [CW-1:0] CNT_SAT  = CW'(TOTAL + 1);

  io_cfg_state_t          r_state;
  io_cfg_state_t          w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic                   w_gate_n;
  logic [NUM_SUBTILE:0]   w_chain;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) r_state <= IO_CFG_IDLE;
    else               r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IO_CFG_IDLE:  if (config_enable) w_state_nxt = IO_CFG_SHIFT;
      IO_CFG_SHIFT: if (!config_enable)
                      w_state_nxt = (r_cnt == CNT_FULL) ? IO_CFG_DONE : IO_CFG_ERR;
      IO_CFG_DONE,
      IO_CFG_ERR:   if (config_enable) w_state_nxt = IO_CFG_SHIFT;
      default:      w_state_nxt = IO_CFG_IDLE;
    endcase
  end

  // The entry edge into SHIFT already shifts one bit, so the cleared count restarts at 1.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_cnt <= '0;
    end else if (config_enable) begin
      if (r_state != IO_CFG_SHIFT) r_cnt <= CW'(1);
      else if (r_cnt != CNT_SAT)   r_cnt <= r_cnt + CW'(1);
    end
  end

  assign cfg_done  = (r_state == IO_CFG_DONE);
  assign cfg_err   = (r_state == IO_CFG_ERR);
  assign w_gate_n  = ~config_enable & (r_state == IO_CFG_DONE);
  assign w_chain[0] = ccff_head;
  assign ccff_tail = w_chain[NUM_SUBTILE];

  for (genvar gi = 0; gi < NUM_SUBTILE; gi++) begin : g_sub
    grid_io_subtile u_sub (
      .i_clk       (prog_clk),
      .i_rst_n     (prog_reset_n),
      .i_shift_en  (config_enable),
      .i_ccff_head (w_chain[gi]),
      .o_ccff_tail (w_chain[gi+1]),
      .i_gate_n    (w_gate_n),
      .i_soc_in    (gfpga_pad_EMBEDDED_IO_SOC_IN[gi]),
      .o_soc_out   (gfpga_pad_EMBEDDED_IO_SOC_OUT[gi]),
      .o_soc_dir   (gfpga_pad_EMBEDDED_IO_SOC_DIR[gi]),
      .i_outpad    (io_outpad[gi]),
      .o_inpad     (io_inpad[gi])
    );
  end

endmodule
